zone_refresh_ctrl: RTL and testbench
====================================

ZONE_REFRESH_CTRL -- requirements
Module: zone_refresh_ctrl

Interface
REQ-001 SHALL have parameter ZONES, default 360, number of backlight zones.
REQ-002 SHALL have parameter DW, default 8, gray bits per zone.
REQ-003 SHALL have parameter AW, default 9, zone address width.
REQ-004 SHALL have port I_clk  input  1  sole clock, rising edge; all logic in this one clock domain.
REQ-005 SHALL have port I_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port I_frame_sync  input  1  one-cycle pulse per video frame, already synchronous to I_clk.
REQ-007 SHALL have port I_led_mode  input  2  00 normal, 01 freeze, 10 test-full, 11 test-off.
REQ-008 SHALL have port I_driver_idle  input  1  high while the LED driver is at a scan boundary and a swap is safe.
REQ-009 SHALL have port O_rd_buf_en  output  1  gray-buffer read enable.
REQ-010 SHALL have port O_array_map  output  AW  gray-buffer read address.
REQ-011 SHALL have port I_rd_data  input  DW  gray-buffer read data, valid exactly 1 cycle after O_rd_buf_en.
REQ-012 SHALL have port O_led_light  output  DW*ZONES  flattened zone brightness to the driver; zone k at bits [k*DW +: DW].
REQ-013 SHALL have port O_update  output  1  one-cycle pulse on each O_led_light commit.
REQ-014 SHALL have port O_busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port O_drop_cnt  output  8  saturating count of dropped frame syncs.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, WAIT_SWAP.
REQ-017 SHALL latch I_led_mode into a frame-mode register on leaving IDLE; mode changes mid-frame SHALL NOT affect the frame in progress.
REQ-018 In IDLE, I_frame_sync (or a pending sync) with mode 00 SHALL go to READ; with 10/11 SHALL fill the shadow with all 8'hFF / 8'h00 and go to WAIT_SWAP; with 01 SHALL stay in IDLE and ignore the sync.
REQ-019 READ SHALL assert O_rd_buf_en for exactly ZONES consecutive cycles with O_array_map 0,1,...,ZONES-1, then go to DRAIN.
REQ-020 Shadow register zone a SHALL capture I_rd_data in the cycle after address a was issued; DRAIN SHALL capture the last zone and go to WAIT_SWAP.
REQ-021 In WAIT_SWAP, on the first edge with I_driver_idle=1, O_led_light SHALL load the shadow, O_update SHALL pulse high for one cycle, and the FSM SHALL return to IDLE.
REQ-022 O_led_light SHALL change only on a commit; readout SHALL never disturb the displayed frame.
REQ-023 A sync arriving outside IDLE SHALL set a one-deep pending flag; if the flag is already set, O_drop_cnt SHALL increment, saturating at 255.
REQ-024 On entering IDLE with pending set, the FSM SHALL start the next frame on the following cycle and clear pending.
REQ-025 A sync in the same cycle as the WAIT_SWAP commit SHALL set pending, not be lost.
REQ-026 O_rd_buf_en SHALL be 0 and O_array_map SHALL hold 0 outside READ.

Reset
REQ-027 Asserting I_rst_n low at any time, including mid-READ, SHALL asynchronously force IDLE, O_rd_buf_en=0, O_array_map=0, O_led_light=0, shadow=0, O_update=0, O_busy=0, O_drop_cnt=0, pending=0.
REQ-028 The first frame after reset deassertion SHALL require a new I_frame_sync.

Structure
REQ-029 ZONES, DW, AW, the FSM state encoding, and the mode codes SHALL live in a shared package, miniled_pkg.
REQ-030 The address counter and capture pipeline SHALL sit in one sub-module, zone_rd_seq; FSM, pending logic and commit SHALL stay in the top.

Verification
REQ-031 Sync pulse in IDLE, mode 00, buffer holding zone k = k mod 256, driver_idle=1 -> 360 reads at addresses 0..359, one commit; zone 359 = 8'h67.
REQ-032 Mode 10 sync -> no reads; O_led_light all 8'hFF after commit; O_update pulses exactly once.
REQ-033 Mode 01, 5 syncs -> no reads, no O_update, O_drop_cnt=0.
REQ-034 Three syncs during one READ -> one pending frame runs next, O_drop_cnt=2.
REQ-035 driver_idle held low 100 cycles in WAIT_SWAP -> O_led_light unchanged, O_busy=1; driver_idle rises -> commit on that edge.
REQ-036 Reset asserted at address 200 -> all outputs zero immediately; no reads until the next sync.

Source files
------------

// File: rtl/miniled_pkg.sv
// Shared definitions for the mini-LED zone refresh path: default geometry,
// controller FSM state encoding and LED mode codes.
package miniled_pkg;

  localparam int unsigned ZONES = 360;  // backlight zones
  localparam int unsigned DW    = 8;    // gray bits per zone
  localparam int unsigned AW    = 9;    // zone address width

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ      = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } state_t;

  // LED mode codes as presented on I_led_mode
  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'b00,
    MODE_FREEZE    = 2'b01,
    MODE_TEST_FULL = 2'b10,
    MODE_TEST_OFF  = 2'b11
  } led_mode_t;

  localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage : miniled_pkg

// File: rtl/zone_rd_seq.sv
// Gray-buffer read sequencer and shadow capture pipeline.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   start_i         begin a ZONES-long read burst from address 0
//   fill_i          load every shadow zone with fill_val_i
//   fill_val_i      constant used by fill_i
//   cap_allow_i     capture gate; high while the frame in flight is a read frame
//   rd_data_i       buffer data, valid one cycle after rd_en_o
//   rd_en_o         buffer read enable (registered)
//   addr_o          buffer read address, 0 when idle (registered)
//   last_c_o        combinational: the final address is being issued this cycle
//   shadow_o        flattened shadow frame, zone k at [k*DW +: DW]
module zone_rd_seq #(
  parameter int unsigned ZONES = miniled_pkg::ZONES,
  parameter int unsigned DW    = miniled_pkg::DW,
  parameter int unsigned AW    = miniled_pkg::AW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                fill_i,
  input  logic [DW-1:0]       fill_val_i,
  input  logic                cap_allow_i,
  input  logic [DW-1:0]       rd_data_i,
  output logic                rd_en_o,
  output logic [AW-1:0]       addr_o,
  output logic                last_c_o,
  output logic [DW*ZONES-1:0] shadow_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ZONES - 1);

  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cap_en_q;
  logic [AW-1:0] cap_addr_q;
  logic [DW-1:0] shadow_q [ZONES];

  // Address counter: runs 0..ZONES-1 once per start, parks at 0
  always_comb begin
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    if (start_i) begin
      rd_en_d = 1'b1;
      addr_d  = '0;
    end else if (rd_en_q) begin
      if (addr_q == LAST_ADDR) begin
        rd_en_d = 1'b0;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  assign last_c_o = rd_en_q && (addr_q == LAST_ADDR);

  // Read enable/address and the one-cycle delayed capture tag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      cap_en_q   <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      cap_en_q   <= rd_en_q;
      cap_addr_q <= addr_q;
    end
  end

  // Shadow frame: bulk fill for test patterns, else per-zone capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int z = 0; z < int'(ZONES); z++) shadow_q[z] <= '0;
    end else if (fill_i) begin
      for (int z = 0; z < int'(ZONES); z++) shadow_q[z] <= fill_val_i;
    end else if (cap_en_q && cap_allow_i) begin
      shadow_q[cap_addr_q] <= rd_data_i;
    end
  end

  for (genvar g = 0; g < int'(ZONES); g++) begin : g_flat
    assign shadow_o[g*DW +: DW] = shadow_q[g];
  end

  assign rd_en_o = rd_en_q;
  assign addr_o  = addr_q;

endmodule : zone_rd_seq

// File: rtl/zone_refresh_ctrl.sv
// Per-frame mini-LED zone refresh controller: on a frame sync it reads the
// gray buffer into a shadow frame (or fills a test pattern) and commits the
// shadow to the driver at the next safe scan boundary.
// Ports:
//   I_clk, I_rst_n   clock, async active-low reset
//   I_frame_sync     one-cycle frame pulse
//   I_led_mode       00 normal, 01 freeze, 10 test-full, 11 test-off
//   I_driver_idle    driver at scan boundary, swap allowed
//   O_rd_buf_en      gray-buffer read enable
//   O_array_map      gray-buffer read address
//   I_rd_data        gray-buffer data, one cycle after the read enable
//   O_led_light      displayed frame, zone k at [k*DW +: DW]
//   O_update         one-cycle pulse per commit
//   O_busy           controller not in IDLE
//   O_drop_cnt       saturating count of dropped frame syncs
module zone_refresh_ctrl #(
  parameter int unsigned ZONES = miniled_pkg::ZONES,
  parameter int unsigned DW    = miniled_pkg::DW,
  parameter int unsigned AW    = miniled_pkg::AW
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_frame_sync,
  input  logic [1:0]          I_led_mode,
  input  logic                I_driver_idle,
  output logic                O_rd_buf_en,
  output logic [AW-1:0]       O_array_map,
  input  logic [DW-1:0]       I_rd_data,
  output logic [DW*ZONES-1:0] O_led_light,
  output logic                O_update,
  output logic                O_busy,
  output logic [7:0]          O_drop_cnt
);

  import miniled_pkg::*;

  state_t                state_q, state_d;
  led_mode_t             mode_q, mode_d;
  logic                  pending_q, pending_d;
  logic [7:0]            drop_q, drop_d;
  logic [DW*ZONES-1:0]   led_q;
  logic                  update_q;
  logic                  busy_q;

  logic                  start_c;
  logic                  fill_c;
  logic [DW-1:0]         fill_val_c;
  logic                  commit_c;
  logic                  last_c;
  logic [DW*ZONES-1:0]   shadow_c;

  zone_rd_seq #(
    .ZONES (ZONES),
    .DW    (DW),
    .AW    (AW)
  ) u_rd_seq (
    .clk_i       (I_clk),
    .rst_ni      (I_rst_n),
    .start_i     (start_c),
    .fill_i      (fill_c),
    .fill_val_i  (fill_val_c),
    .cap_allow_i (mode_q == MODE_NORMAL),
    .rd_data_i   (I_rd_data),
    .rd_en_o     (O_rd_buf_en),
    .addr_o      (O_array_map),
    .last_c_o    (last_c),
    .shadow_o    (shadow_c)
  );

  // Next-state, frame start, commit and sync bookkeeping
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pending_d  = pending_q;
    drop_d     = drop_q;
    start_c    = 1'b0;
    fill_c     = 1'b0;
    fill_val_c = '0;
    commit_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A pending sync is consumed here whether or not a frame starts
        if (I_frame_sync || pending_q) begin
          pending_d = 1'b0;
          case (led_mode_t'(I_led_mode))
            MODE_NORMAL: begin
              mode_d  = MODE_NORMAL;
              start_c = 1'b1;
              state_d = ST_READ;
            end
            MODE_TEST_FULL: begin
              mode_d     = MODE_TEST_FULL;
              fill_c     = 1'b1;
              fill_val_c = {DW{1'b1}};
              state_d    = ST_WAIT_SWAP;
            end
            MODE_TEST_OFF: begin
              mode_d     = MODE_TEST_OFF;
              fill_c     = 1'b1;
              fill_val_c = '0;
              state_d    = ST_WAIT_SWAP;
            end
            default: ;  // freeze: sync ignored
          endcase
        end
      end
      ST_READ: begin
        if (last_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_WAIT_SWAP;
      end
      ST_WAIT_SWAP: begin
        if (I_driver_idle) begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Syncs outside IDLE (including the commit cycle) queue one frame deep
    if (I_frame_sync && (state_q != ST_IDLE)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (drop_q != DROP_MAX) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_NORMAL;
      pending_q <= 1'b0;
      drop_q    <= '0;
      led_q     <= '0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      update_q  <= commit_c;
      busy_q    <= (state_d != ST_IDLE);
      if (commit_c) led_q <= shadow_c;
    end
  end

  assign O_led_light = led_q;
  assign O_update    = update_q;
  assign O_busy      = busy_q;
  assign O_drop_cnt  = drop_q;

endmodule : zone_refresh_ctrl

// File: tb/tb_zone_refresh_ctrl.sv
// Directed bench for zone_refresh_ctrl: table of single-frame vectors plus
// hand-written sequences for pending syncs, delayed swap and mid-read reset.
module tb_zone_refresh_ctrl;

  localparam int unsigned ZONES = 360;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 9;

  logic                clk      = 1'b0;
  logic                rst_n    = 1'b0;
  logic                sync     = 1'b0;
  logic [1:0]          mode     = 2'b00;
  logic                drv_idle = 1'b1;
  logic [DW-1:0]       rd_data  = '0;
  logic                rd_en;
  logic [AW-1:0]       map;
  logic [DW*ZONES-1:0] led;
  logic                upd;
  logic                busy;
  logic [7:0]          drop;

  int seed = 0;

  always #5 clk = ~clk;

  zone_refresh_ctrl #(.ZONES(ZONES), .DW(DW), .AW(AW)) dut (
    .I_clk         (clk),
    .I_rst_n       (rst_n),
    .I_frame_sync  (sync),
    .I_led_mode    (mode),
    .I_driver_idle (drv_idle),
    .O_rd_buf_en   (rd_en),
    .O_array_map   (map),
    .I_rd_data     (rd_data),
    .O_led_light   (led),
    .O_update      (upd),
    .O_busy        (busy),
    .O_drop_cnt    (drop)
  );

  // Gray buffer model: zone k holds (k + seed) mod 256, one-cycle latency
  always @(posedge clk) begin
    if (rd_en) rd_data <= DW'(int'(map) + seed);
  end

  // Read/update monitor sampled on the falling edge
  int read_total = 0, upd_total = 0, addr_err = 0, map_err = 0, exp_addr = 0;
  always @(negedge clk) begin
    if (rd_en) begin
      if (int'(map) != exp_addr) addr_err++;
      exp_addr++;
      read_total++;
    end else begin
      exp_addr = 0;
      if (map != '0) map_err++;
    end
    if (upd) upd_total++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int zone(input int k);
    return int'(led[k*DW +: DW]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_pulse();
    @(posedge clk); #1 sync = 1'b1;
    @(posedge clk); #1 sync = 1'b0;
  endtask

  task automatic wait_upd(input int target, input int budget, input string name);
    int i = 0;
    while (upd_total < target && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check({name, " update wait"}, 32'(upd_total >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while (busy && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    check({name, " idle wait"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         seed;
    int         n_sync;
    int         exp_reads;
    int         exp_upd;
    int         z0;
    int         z200;
    int         z359;
  } vec_t;

  vec_t vt[5];

  initial begin
    int r0, u0, bad, i;
    string nm;

    vt[0] = '{2'b00, 0, 1, 360, 1, 'h00, 'hC8, 'h67};
    vt[1] = '{2'b10, 0, 1,   0, 1, 'hFF, 'hFF, 'hFF};
    vt[2] = '{2'b11, 0, 1,   0, 1, 'h00, 'h00, 'h00};
    vt[3] = '{2'b00, 5, 1, 360, 1, 'h05, 'hCD, 'h6C};
    vt[4] = '{2'b01, 9, 5,   0, 0, 'h05, 'hCD, 'h6C};

    // Reset state
    cyc(2);
    @(negedge clk);
    check("rst rd_en", 32'(rd_en), 0);
    check("rst map", 32'(map), 0);
    check("rst led zero", 32'(led == '0), 1);
    check("rst busy", 32'(busy), 0);
    check("rst drop", 32'(drop), 0);
    rst_n = 1'b1;
    cyc(3);

    // Single-frame vectors
    for (int v = 0; v < 5; v++) begin
      nm = $sformatf("v%0d", v);
      r0 = read_total;
      u0 = upd_total;
      mode = vt[v].mode;
      seed = vt[v].seed;
      for (int s = 0; s < vt[v].n_sync; s++) sync_pulse();
      if (vt[v].exp_upd > 0) wait_upd(u0 + vt[v].exp_upd, 2000, nm);
      else cyc(20);
      wait_idle(100, nm);
      cyc(2);
      @(negedge clk);
      check({nm, " reads"}, 32'(read_total - r0), 32'(vt[v].exp_reads));
      check({nm, " updates"}, 32'(upd_total - u0), 32'(vt[v].exp_upd));
      check({nm, " zone0"}, 32'(zone(0)), 32'(vt[v].z0));
      check({nm, " zone200"}, 32'(zone(200)), 32'(vt[v].z200));
      check({nm, " zone359"}, 32'(zone(359)), 32'(vt[v].z359));
      check({nm, " drop"}, 32'(drop), 0);
      check({nm, " addr seq"}, 32'(addr_err), 0);
      check({nm, " map idle"}, 32'(map_err), 0);
      if (vt[v].mode[1]) begin
        bad = 0;
        for (int k = 0; k < int'(ZONES); k++) if (zone(k) != vt[v].z0) bad++;
        check({nm, " all zones"}, 32'(bad), 0);
      end
    end

    // Three syncs during one READ: one pending frame, two drops
    r0 = read_total;
    u0 = upd_total;
    mode = 2'b00;
    seed = 0;
    sync_pulse();
    cyc(10);
    repeat (3) sync_pulse();
    wait_upd(u0 + 2, 3000, "pend");
    wait_idle(1000, "pend");
    cyc(20);
    @(negedge clk);
    check("pend reads", 32'(read_total - r0), 720);
    check("pend updates", 32'(upd_total - u0), 2);
    check("pend drop", 32'(drop), 2);
    check("pend zone359", 32'(zone(359)), 'h67);

    // Driver busy for 100 cycles in WAIT_SWAP, then commit with a coincident sync
    r0 = read_total;
    u0 = upd_total;
    seed = 5;
    drv_idle = 1'b0;
    sync_pulse();
    i = 0;
    while (read_total < r0 + 360 && i < 1000) begin
      @(posedge clk);
      i++;
    end
    check("swap read wait", 32'(read_total >= r0 + 360), 1);
    cyc(105);
    @(negedge clk);
    check("swap hold busy", 32'(busy), 1);
    check("swap hold no update", 32'(upd_total - u0), 0);
    check("swap hold zone359", 32'(zone(359)), 'h67);
    @(posedge clk); #1;
    drv_idle = 1'b1;
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    @(negedge clk);
    check("swap commit pulse", 32'(upd), 1);
    check("swap commit zone359", 32'(zone(359)), 'h6C);
    wait_upd(u0 + 2, 2000, "swap");
    wait_idle(100, "swap");
    cyc(10);
    @(negedge clk);
    check("swap reads", 32'(read_total - r0), 720);
    check("swap drop", 32'(drop), 2);

    // Reset asserted while address 200 is on the bus
    seed = 0;
    sync_pulse();
    i = 0;
    while (!(rd_en && map == AW'(200)) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("rst200 reached", 32'(rd_en && map == AW'(200)), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst200 rd_en", 32'(rd_en), 0);
    check("rst200 map", 32'(map), 0);
    check("rst200 led zero", 32'(led == '0), 1);
    check("rst200 update", 32'(upd), 0);
    check("rst200 busy", 32'(busy), 0);
    check("rst200 drop", 32'(drop), 0);
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = read_total;
    u0 = upd_total;
    cyc(50);
    check("rst200 no reads", 32'(read_total - r0), 0);
    check("rst200 no update", 32'(upd_total - u0), 0);
    sync_pulse();
    wait_upd(u0 + 1, 2000, "rst200 frame");
    wait_idle(100, "rst200 frame");
    @(negedge clk);
    check("rst200 frame reads", 32'(read_total - r0), 360);
    check("rst200 frame zone200", 32'(zone(200)), 'hC8);
    check("rst200 frame zone359", 32'(zone(359)), 'h67);
    check("rst200 addr seq", 32'(addr_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_zone_refresh_ctrl
